// File: rtl/normaliza_pf_pkg.sv
// Shared types and constants for the single-precision normalize/round/pack stage.
package pf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } norm_state_t;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  // Extended mantissa layout: carry, hidden, 23-bit fraction, guard, sticky
  localparam int CARRY_BIT  = 26;
  localparam int HIDDEN_BIT = 25;
  localparam int LSB_BIT    = 2;
  localparam int GUARD_BIT  = 1;
  localparam int STICKY_BIT = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

endpackage

// File: rtl/normaliza_pf_if.sv
// Valid/ready bus between the adder datapath (master) and the normalizer (slave).
interface normaliza_pf_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic [EXP_W-1:0]        in_exp;
  logic [FRAC_W+3:0]       in_mant;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   out_result;
  logic                    out_overflow;
  logic                    out_underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow
  );
endinterface

// File: rtl/normaliza_pf_redondeo.sv
// redondeo_pf: combinational round-to-nearest-even of {hidden, frac, guard, sticky}.
module redondeo_pf
  import pf_pkg::*;
#(
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W+2:0] mant_i,
  output logic [FRAC_W:0]   sum_o,
  output logic              carry_o
);
  logic round_up;

  assign round_up = mant_i[GUARD_BIT] & (mant_i[STICKY_BIT] | mant_i[LSB_BIT]);
  assign {carry_o, sum_o} = {1'b0, mant_i[FRAC_W+2:LSB_BIT]} + (FRAC_W+2)'(round_up);
endmodule

// File: rtl/normaliza_pf.sv
// normaliza_pf: multi-cycle normalize/round/pack of a raw single-precision sum.
// Build option NORMALIZA_PF_SUBNORMAL_EN keeps subnormals instead of flushing to zero.
module normaliza_pf
  import pf_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic           clk,
  input  logic           rst,
  normaliza_pf_if.slave  bus
);
  localparam int CB = FRAC_W + 3;
  localparam int HB = FRAC_W + 2;
  localparam int RW = EXP_W + FRAC_W + 1;
  localparam logic [EXP_W:0] EXP_SAT = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_ROUND = ST_ROUND;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic [CB:0]       mant_q, mant_d;
  logic [RW-1:0]     res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [FRAC_W:0]   rnd_sum;
  logic              rnd_carry;
  logic [EXP_W:0]    exp_r;
  logic              hidden_r;
  logic [FRAC_W-1:0] frac_r;

  redondeo_pf #(.FRAC_W(FRAC_W)) u_redondeo (
    .mant_i  (mant_q[HB:0]),
    .sum_o   (rnd_sum),
    .carry_o (rnd_carry)
  );

  // A rounding carry leaves 1.000..0 above the hidden bit; renormalize by one.
  assign exp_r    = exp_q + (EXP_W+1)'(rnd_carry);
  assign hidden_r = rnd_carry | rnd_sum[FRAC_W];
  assign frac_r   = rnd_carry ? rnd_sum[FRAC_W:1] : rnd_sum[FRAC_W-1:0];

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_sign;
          exp_d   = {1'b0, bus.in_exp};
          mant_d  = bus.in_mant;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (exp_q == EXP_SAT) begin
          res_d   = {sign_q, exp_q[EXP_W-1:0], mant_q[FRAC_W+1:2]};
          state_d = S_DONE;
        end else if (mant_q == '0) begin
          res_d   = '0;
          state_d = S_DONE;
        end else if (mant_q[CB]) begin
          mant_d  = {1'b0, mant_q[CB:2], mant_q[1] | mant_q[0]};
          exp_d   = exp_q + EXP_ONE;
          state_d = S_ROUND;
        end else if (!mant_q[HB] && (exp_q > EXP_ONE)) begin
          mant_d  = {mant_q[HB:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
        end else if (!mant_q[HB]) begin
`ifdef NORMALIZA_PF_SUBNORMAL_EN
          state_d = S_ROUND;
`else
          res_d   = {sign_q, {(RW-1){1'b0}}};
          unf_d   = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (exp_r >= EXP_SAT) begin
          res_d = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_d = 1'b1;
        end else begin
          // Hidden bit still clear means a subnormal (or zero): exponent field encodes 0.
          res_d = {sign_q, (hidden_r ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), frac_r};
          unf_d = ~hidden_r;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.in_ready      = (state_q == S_IDLE);
  assign bus.out_valid     = (state_q == S_DONE);
  assign bus.out_result    = (state_q == S_DONE) ? res_q : '0;
  assign bus.out_overflow  = (state_q == S_DONE) & ovf_q;
  assign bus.out_underflow = (state_q == S_DONE) & unf_q;
endmodule
